// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: counts rows landed in a (KER+1)-row line buffer and
// issues one window descriptor per (out_y, out_x, fmap) in raster order.
// Optional feature macro: WIN_SCHED_PERF_EN enables the perf_stall_cnt counter.
module conv_window_scheduler #(
    parameter int unsigned IN_X     = 32,
    parameter int unsigned IN_Y     = 32,
    parameter int unsigned KER      = 5,
    parameter int unsigned STRIDE_X = 1,
    parameter int unsigned STRIDE_Y = 1,
    parameter int unsigned NFMAPS   = 6,
    localparam int unsigned OUT_X   = (IN_X - KER) / STRIDE_X + 1,
    localparam int unsigned OUT_Y   = (IN_Y - KER) / STRIDE_Y + 1,
    localparam int unsigned AW      = $clog2(IN_X),
    localparam int unsigned FW      = (NFMAPS > 1) ? $clog2(NFMAPS) : 1,
    localparam int unsigned XW      = (OUT_X > 1) ? $clog2(OUT_X) : 1,
    localparam int unsigned YW      = (OUT_Y > 1) ? $clog2(OUT_Y) : 1,
    localparam int unsigned RW      = $clog2(KER + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          lb_row_done,
    output logic          lb_hold,
    output logic          lb_flush,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [AW-1:0] win_col,
    output logic [FW-1:0] win_fmap,
    output logic          win_last,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun,
    output logic [15:0]   perf_stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_DONE} state_t;

    state_t        state;
    logic [RW-1:0] rows_avail;
    logic [RW-1:0] rows_nxt;
    logic          hs;
    logic          f_last;
    logic          x_last;
    logic          y_last;
    logic          row_end;
    logic          row_inc;
    logic [FW-1:0] nx_fmap;
    logic [XW-1:0] nx_x;
    logic [YW-1:0] nx_y;
    logic [AW-1:0] nx_col;
    logic          nx_last;

    assign hs      = win_valid & win_ready;
    assign f_last  = (win_fmap == FW'(NFMAPS - 1));
    assign x_last  = (out_x == XW'(OUT_X - 1));
    assign y_last  = (out_y == YW'(OUT_Y - 1));
    assign row_end = hs & f_last & x_last;
    assign lb_hold = (rows_avail == RW'(KER + 1));
    assign row_inc = lb_row_done & (state != S_IDLE) & ~lb_hold;

    // Next raster position after a handshake, and the line-buffer occupancy update
    always_comb begin
        nx_fmap = win_fmap;
        nx_x    = out_x;
        nx_y    = out_y;
        nx_col  = win_col;
        if (hs) begin
            if (f_last) begin
                nx_fmap = '0;
                if (x_last) begin
                    nx_x   = '0;
                    nx_col = '0;
                    if (!y_last) begin
                        nx_y = out_y + YW'(1);
                    end
                end else begin
                    nx_x   = out_x + XW'(1);
                    nx_col = win_col + AW'(STRIDE_X);
                end
            end else begin
                nx_fmap = win_fmap + FW'(1);
            end
        end
        nx_last  = (nx_fmap == FW'(NFMAPS - 1)) && (nx_x == XW'(OUT_X - 1)) && y_last;
        rows_nxt = rows_avail + RW'(row_inc) - (row_end ? RW'(STRIDE_Y) : RW'(0));
    end

    // Frame sequencer: fill, issue, done, with abort overriding everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rows_avail <= '0;
            win_valid  <= 1'b0;
            win_col    <= '0;
            win_fmap   <= '0;
            win_last   <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            busy       <= 1'b0;
            lb_flush   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            lb_flush   <= 1'b0;
            frame_done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                lb_flush   <= 1'b1;
                win_valid  <= 1'b0;
                win_last   <= 1'b0;
                rows_avail <= '0;
                win_col    <= '0;
                win_fmap   <= '0;
                out_x      <= '0;
                out_y      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state      <= S_FILL;
                            busy       <= 1'b1;
                            lb_flush   <= 1'b1;
                            rows_avail <= '0;
                            win_col    <= '0;
                            win_fmap   <= '0;
                            out_x      <= '0;
                            out_y      <= '0;
                            overrun    <= 1'b0;
                        end
                    end
                    S_FILL: begin
                        rows_avail <= rows_nxt;
                        if (rows_avail >= RW'(KER)) begin
                            state     <= S_ISSUE;
                            win_valid <= 1'b1;
                            win_last  <= f_last & x_last & y_last;
                        end
                    end
                    S_ISSUE: begin
                        rows_avail <= rows_nxt;
                        win_fmap   <= nx_fmap;
                        out_x      <= nx_x;
                        out_y      <= nx_y;
                        win_col    <= nx_col;
                        if (row_end) begin
                            win_valid <= 1'b0;
                            win_last  <= 1'b0;
                            if (y_last) begin
                                state      <= S_DONE;
                                frame_done <= 1'b1;
                            end else begin
                                state <= S_FILL;
                            end
                        end else begin
                            win_last <= nx_last;
                        end
                    end
                    default: begin
                        rows_avail <= rows_nxt;
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                    end
                endcase
                if (state != S_IDLE && lb_row_done && lb_hold) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef WIN_SCHED_PERF_EN
    // Saturating count of busy cycles without a descriptor handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= 16'h0;
        end else if (state == S_IDLE && start && !abort) begin
            perf_stall_cnt <= 16'h0;
        end else if (state != S_IDLE && !hs && perf_stall_cnt != 16'hFFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 16'h1;
        end
    end
`else
    assign perf_stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler: two 8x8/KER=3/NFMAPS=2 instances
// (stride 1 and stride 2) checked against a descriptor-list reference model.
module tb_conv_window_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic lb_row_done = 1'b0;
    logic win_ready = 1'b0;
    bit   sel = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic       d1_hold, d1_flush, d1_valid, d1_last, d1_busy, d1_done, d1_ovr;
    logic [2:0] d1_col;
    logic [0:0] d1_fmap;
    logic [2:0] d1_x, d1_y;
    logic [15:0] d1_perf;
    logic       d2_hold, d2_flush, d2_valid, d2_last, d2_busy, d2_done, d2_ovr;
    logic [2:0] d2_col;
    logic [0:0] d2_fmap;
    logic [1:0] d2_x, d2_y;
    logic [15:0] d2_perf;

    conv_window_scheduler #(.IN_X(8), .IN_Y(8), .KER(3), .STRIDE_X(1), .STRIDE_Y(1), .NFMAPS(2)) dut (
        .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort), .lb_row_done(lb_row_done),
        .lb_hold(d1_hold), .lb_flush(d1_flush), .win_valid(d1_valid), .win_ready(win_ready),
        .win_col(d1_col), .win_fmap(d1_fmap), .win_last(d1_last), .out_x(d1_x), .out_y(d1_y),
        .busy(d1_busy), .frame_done(d1_done), .overrun(d1_ovr), .perf_stall_cnt(d1_perf)
    );

    conv_window_scheduler #(.IN_X(8), .IN_Y(8), .KER(3), .STRIDE_X(2), .STRIDE_Y(2), .NFMAPS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start & sel), .abort(abort), .lb_row_done(lb_row_done),
        .lb_hold(d2_hold), .lb_flush(d2_flush), .win_valid(d2_valid), .win_ready(win_ready),
        .win_col(d2_col), .win_fmap(d2_fmap), .win_last(d2_last), .out_x(d2_x), .out_y(d2_y),
        .busy(d2_busy), .frame_done(d2_done), .overrun(d2_ovr), .perf_stall_cnt(d2_perf)
    );

    // Selected instance view
    logic        o_hold, o_flush, o_valid, o_last, o_busy, o_done, o_ovr;
    logic [2:0]  o_col, o_x, o_y;
    logic        o_fmap;
    logic [15:0] o_perf;
    assign o_hold  = sel ? d2_hold  : d1_hold;
    assign o_flush = sel ? d2_flush : d1_flush;
    assign o_valid = sel ? d2_valid : d1_valid;
    assign o_last  = sel ? d2_last  : d1_last;
    assign o_busy  = sel ? d2_busy  : d1_busy;
    assign o_done  = sel ? d2_done  : d1_done;
    assign o_ovr   = sel ? d2_ovr   : d1_ovr;
    assign o_col   = sel ? d2_col   : d1_col;
    assign o_fmap  = sel ? d2_fmap[0] : d1_fmap[0];
    assign o_x     = sel ? {1'b0, d2_x} : d1_x;
    assign o_y     = sel ? {1'b0, d2_y} : d1_y;
    assign o_perf  = sel ? d2_perf  : d1_perf;

    typedef struct {
        int col;
        int fmap;
        int x;
        int y;
        bit last;
    } desc_t;

    desc_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference descriptor list: raster order of (y, x, fmap), column = x*stride
    task automatic build(input bit s);
        int sx;
        int nx;
        int ny;
        sx = s ? 2 : 1;
        nx = (8 - 3) / sx + 1;
        ny = (8 - 3) / sx + 1;
        exp_q.delete();
        for (int y = 0; y < ny; y++)
            for (int x = 0; x < nx; x++)
                for (int f = 0; f < 2; f++)
                    exp_q.push_back('{x * sx, f, x, y, (y == ny - 1) && (x == nx - 1) && (f == 1)});
    endtask

    task automatic run_frame(input bit s, input int rdy_pct, input int abort_y, input int stall_at);
        int sy;
        int per_row;
        int total;
        int fed;
        int avail;
        int pre_avail;
        int hs_cnt;
        int perf_m;
        int cyc;
        int stall_left;
        bit stalled;
        bit exp_valid;
        bit filling;
        bit fin;
        bit rdy;
        bit row;
        bit hs;
        bit rc;
        sel = s;
        build(s);
        sy = s ? 2 : 1;
        per_row = (s ? 3 : 6) * 2;
        total = exp_q.size();
        fed = 0; avail = 0; hs_cnt = 0; perf_m = 0; cyc = 0; stall_left = 0;
        stalled = 0; exp_valid = 0; filling = 1; fin = 0;
        @(negedge clk);
        start = 1'b1; win_ready = 1'b0; lb_row_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_flush", 32'(o_flush), 32'd1);
        chk("start_busy", 32'(o_busy), 32'd1);
        chk("start_ovr_clr", 32'(o_ovr), 32'd0);
        while (!fin && cyc < 4000) begin
            chk("hold", 32'(o_hold), 32'(avail == 4));
            chk("valid", 32'(o_valid), 32'(exp_valid));
            chk("done_low", 32'(o_done), 32'd0);
            if (exp_valid) begin
                chk("col", 32'(o_col), 32'(exp_q[hs_cnt].col));
                chk("fmap", 32'(o_fmap), 32'(exp_q[hs_cnt].fmap));
                chk("out_x", 32'(o_x), 32'(exp_q[hs_cnt].x));
                chk("out_y", 32'(o_y), 32'(exp_q[hs_cnt].y));
                chk("last", 32'(o_last), 32'(exp_q[hs_cnt].last));
            end else begin
                chk("last_idle", 32'(o_last), 32'd0);
            end
            if (abort_y >= 0 && exp_valid && exp_q[hs_cnt].y == abort_y) begin
                win_ready = 1'b0; lb_row_done = 1'b0; abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", 32'(o_busy), 32'd0);
                chk("abort_flush", 32'(o_flush), 32'd1);
                chk("abort_valid", 32'(o_valid), 32'd0);
                chk("abort_done", 32'(o_done), 32'd0);
                @(negedge clk);
                chk("abort_flush_pulse", 32'(o_flush), 32'd0);
                repeat (3) begin
                    chk("abort_no_done", 32'(o_done), 32'd0);
                    chk("abort_idle", 32'(o_busy), 32'd0);
                    @(negedge clk);
                end
                return;
            end
            if (stall_at >= 0 && !stalled && exp_valid && hs_cnt == stall_at) begin
                stall_left = 5;
                stalled = 1;
            end
            if (stall_left > 0) begin
                rdy = 0;
                stall_left--;
            end else begin
                rdy = ($urandom_range(99) < rdy_pct);
            end
            hs = exp_valid && rdy;
            rc = hs && ((hs_cnt + 1) % per_row == 0);
            row = (fed < 8) && !o_hold && (rc || $urandom_range(1) == 1);
            win_ready = rdy;
            lb_row_done = row;
            if (!hs) perf_m++;
            pre_avail = avail;
            if (row) begin
                fed++;
                if (avail < 4) avail++;
            end
            if (rc) avail -= sy;
            if (hs) hs_cnt++;
            if (rc) begin
                exp_valid = 0;
                if (hs_cnt == total) fin = 1;
                else filling = 1;
            end else if (filling && pre_avail >= 3) begin
                filling = 0;
                exp_valid = 1;
            end
            cyc++;
            @(negedge clk);
        end
        win_ready = 1'b0;
        lb_row_done = 1'b0;
        chk("frame_end_reached", 32'(fin), 32'd1);
        if (fin) begin
            perf_m++;
            chk("frame_done", 32'(o_done), 32'd1);
            chk("done_busy", 32'(o_busy), 32'd1);
            chk("done_valid", 32'(o_valid), 32'd0);
            @(negedge clk);
            chk("idle_busy", 32'(o_busy), 32'd0);
            chk("done_pulse", 32'(o_done), 32'd0);
            chk("hs_count", 32'(hs_cnt), 32'(total));
`ifdef WIN_SCHED_PERF_EN
            chk("perf", 32'(o_perf), 32'(perf_m));
`else
            chk("perf_tied", 32'(o_perf), 32'd0);
`endif
        end
    endtask

    initial begin
        // Reset values on both instances
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_hold", 32'(o_hold), 32'd0);
            chk("rst_flush", 32'(o_flush), 32'd0);
            chk("rst_ovr", 32'(o_ovr), 32'd0);
            chk("rst_col", 32'(o_col), 32'd0);
            chk("rst_perf", 32'(o_perf), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_frame(1'b0, 100, -1, -1);
        run_frame(1'b1, 100, -1, -1);
        run_frame(1'b0, 100, -1, 3);
        run_frame(1'b0, 60, -1, -1);
        run_frame(1'b1, 50, -1, -1);

        // Buffer fills with no consumption, then an extra row overruns
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; win_ready = 1'b0;
        repeat (4) begin
            lb_row_done = 1'b1;
            @(negedge clk);
            lb_row_done = 1'b0;
            @(negedge clk);
        end
        chk("ovr_hold_full", 32'(o_hold), 32'd1);
        chk("ovr_not_yet", 32'(o_ovr), 32'd0);
        chk("ovr_valid", 32'(o_valid), 32'd1);
        lb_row_done = 1'b1;
        @(negedge clk);
        lb_row_done = 1'b0;
        chk("ovr_set", 32'(o_ovr), 32'd1);
        @(negedge clk);
        chk("ovr_hold_stays", 32'(o_hold), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ovr_abort_busy", 32'(o_busy), 32'd0);
        chk("ovr_sticky", 32'(o_ovr), 32'd1);

        run_frame(1'b0, 100, 2, -1);
        run_frame(1'b0, 80, -1, -1);

        // Asynchronous reset mid-frame
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            lb_row_done = 1'b1;
            @(negedge clk);
        end
        lb_row_done = 1'b0;
        chk("pre_rst_hold", 32'(o_hold), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_hold", 32'(o_hold), 32'd0);
        chk("arst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_no_done", 32'(o_done), 32'd0);

        run_frame(1'b1, 70, -1, -1);
        run_frame(1'b0, 90, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
